alu_exec_unit: RTL and testbench

- Multi-cycle ALU execution unit that consumes the 4-bit ALU select code produced by the ALU control decoder, together with two XLEN-bit operands.
- Single-cycle ops complete in 1 cycle; shifts are iterative, 1 bit per cycle.
- Sits in the EX stage between operand muxes and the EX/MEM register.
- Uses a valid/ready handshake on both input and output, and a flush input for pipeline kills.

---
 rtl/alu_exec_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle EX-stage ALU with iterative 1-bit/cycle shifter
//
// Purpose: executes one ALU op per valid/ready handshake. Single-cycle ops
// finish with latency 1; SLL/SRL/SRA walk one bit per cycle (latency shamt+1).
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   flush_i              synchronous kill of whatever is in flight
//   in_valid_i/in_ready_o, op_i, a_i, b_i     operation input handshake
//   out_valid_o/out_ready_i, result_o, zero_o, illegal_o  result handshake

module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] shreg_q;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;
    logic            out_valid_q;

    logic [XLEN-1:0] alu_res_d;
    logic            alu_ill_d;
    logic            is_shift_d;
    logic [SHW-1:0]  shamt_d;
    logic [XLEN-1:0] shreg_d;

    assign shamt_d = b_i[SHW-1:0];

    // Single-cycle datapath on the live inputs; shifts only use a_i here
    // for the shamt==0 case, which completes without entering SHIFT.
    always_comb begin
        alu_res_d  = '0;
        alu_ill_d  = 1'b0;
        is_shift_d = 1'b0;
        case (op_i)
            ALU_ADD:  alu_res_d = a_i + b_i;
            ALU_SUB:  alu_res_d = a_i - b_i;
            ALU_AND:  alu_res_d = a_i & b_i;
            ALU_OR:   alu_res_d = a_i | b_i;
            ALU_XOR:  alu_res_d = a_i ^ b_i;
            ALU_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                alu_res_d  = a_i;
                is_shift_d = 1'b1;
            end
            default:  alu_ill_d = 1'b1;
        endcase
    end

    // One-bit shift step for the op latched at accept.
    always_comb begin
        shreg_d = shreg_q;
        case (op_q)
            ALU_SLL: shreg_d = {shreg_q[XLEN-2:0], 1'b0};
            ALU_SRL: shreg_d = {1'b0, shreg_q[XLEN-1:1]};
            ALU_SRA: shreg_d = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: shreg_d = shreg_q;
        endcase
    end

    // result_q is written only on entry to DONE, so it never exposes a
    // partially shifted value and stays frozen while the output stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        op_q <= op_i;
                        if (is_shift_d && (shamt_d != '0)) begin
                            shreg_q <= a_i;
                            cnt_q   <= shamt_d;
                            state_q <= S_SHIFT;
                        end else begin
                            result_q    <= alu_res_d;
                            zero_q      <= (alu_res_d == '0);
                            illegal_q   <= alu_ill_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - {{(SHW-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                        result_q    <= shreg_d;
                        zero_q      <= (shreg_d == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .zero_o      (zero),
        .illegal_o   (illegal)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
        string       nm;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    vec_t tbl[13];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one op, measure accept-to-out_valid latency, compare the result
    // against the scoreboard entry pushed at drive time, then hand it off.
    task automatic do_op(input vec_t v);
        exp_t e;
        int   lat;
        int   n;
        logic busy_ok;
        e.res = v.res; e.z = v.z; e.ill = v.ill;
        sb.push_back(e);
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({v.nm, " latency"}, lat, v.lat);
        if (v.lat > 1) chk({v.nm, " in_ready low while shifting"}, {31'd0, busy_ok}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({v.nm, " result"}, result, e.res);
            chk({v.nm, " zero"}, {31'd0, zero}, {31'd0, e.z});
            chk({v.nm, " illegal"}, {31'd0, illegal}, {31'd0, e.ill});
        end
        @(posedge clk);
    endtask

    initial begin
        tbl[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h1,  32'h80000000, 1'b0, 1'b0, 1,  "add_ovf"};
        tbl[1]  = '{ALU_SUB,  32'h5,        32'h5,  32'h0,        1'b1, 1'b0, 1,  "sub_zero"};
        tbl[2]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h1,  32'h1,        1'b0, 1'b0, 1,  "slt"};
        tbl[3]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h1,  32'h0,        1'b1, 1'b0, 1,  "sltu"};
        tbl[4]  = '{ALU_AND,  32'hF0F0A5A5, 32'hFF00FF00, 32'hF000A500, 1'b0, 1'b0, 1, "and"};
        tbl[5]  = '{ALU_OR,   32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b0, 1, "or"};
        tbl[6]  = '{ALU_SRA,  32'h80000000, 32'h1F, 32'hFFFFFFFF, 1'b0, 1'b0, 32, "sra31"};
        tbl[7]  = '{ALU_SRL,  32'h80000000, 32'h1F, 32'h00000001, 1'b0, 1'b0, 32, "srl31"};
        tbl[8]  = '{ALU_SLL,  32'h1,        32'h20, 32'h1,        1'b0, 1'b0, 1,  "sll_sh0"};
        tbl[9]  = '{ALU_SLL,  32'h3,        32'h4,  32'h30,       1'b0, 1'b0, 5,  "sll4"};
        tbl[10] = '{ALU_SRA,  32'h7FFFFFF0, 32'h4,  32'h07FFFFFF, 1'b0, 1'b0, 5,  "sra_pos"};
        tbl[11] = '{4'hF,     32'h12345678, 32'h9,  32'h0,        1'b1, 1'b1, 1,  "undef"};
        tbl[12] = '{ALU_SRL,  32'h1,        32'h1,  32'h0,        1'b1, 1'b0, 2,  "srl_to_zero"};

        #12;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd0);
        chk("reset illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) do_op(tbl[i]);

        // Backpressure: ADD 3+4 held, second op (XOR 1^2) must wait.
        @(negedge clk);
        op = ALU_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        op = ALU_XOR; a = 32'd1; b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp result held", result, 32'd7);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp idle out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp idle in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp second valid", {31'd0, out_valid}, 32'd1);
        chk("bp second result", result, 32'd3);
        @(negedge clk);

        // Flush in cycle 3 of SLL 1<<10: nothing may come out for it.
        op = ALU_SLL; a = 32'd1; b = 32'd10; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 14; i++) begin
                if (out_valid) seen = 1'b1;
                @(negedge clk);
            end
            chk("flush no out_valid", {31'd0, seen}, 32'd0);
        end
        begin
            vec_t v;
            v = '{ALU_XOR, 32'hF0, 32'hFF, 32'h0F, 1'b0, 1'b0, 1, "xor_after_flush"};
            do_op(v);
        end

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        op = ALU_SLL; a = 32'd1; b = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst release in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst release out_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
